// File: rtl/axi_ic_pkg.sv
// ---------------------------------------------------------------------------
// axi_ic_pkg
// Shared types and helpers for the interconnect write/read data routers.
//   wr_route_state_e : write-data router FSM states (IDLE, BURST, POP)
//   strb_width()     : byte-strobe width for a given data width
// ---------------------------------------------------------------------------
package axi_ic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        POP   = 2'd2
    } wr_route_state_e;

    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_STRB_WIDTH = DEF_DATA_WIDTH / BYTE_BITS;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/wdata_slice_mux.sv
// ---------------------------------------------------------------------------
// wdata_slice_mux
// Selects one master's data/strobe/valid/last slice by index and routes the
// slave ready back to that master only. With i_en low every output is 0.
// Ports:
//   i_en     : enable routing
//   i_sel    : selected master index
//   i_data   : packed master data,    master i at [i*DW +: DW]
//   i_strb   : packed master strobes, master i at [i*SW +: SW]
//   i_valid  : per-master valid
//   i_last   : per-master last
//   i_ready  : downstream ready
//   o_data/o_strb/o_valid/o_last : selected slice
//   o_ready  : per-master ready (only the selected bit can be high)
// ---------------------------------------------------------------------------
module wdata_slice_mux
    import axi_ic_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1,
    parameter int DW = 32,
    parameter int SW = strb_width(DW)
) (
    input  logic              i_en,
    input  logic [IW-1:0]     i_sel,
    input  logic [N*DW-1:0]   i_data,
    input  logic [N*SW-1:0]   i_strb,
    input  logic [N-1:0]      i_valid,
    input  logic [N-1:0]      i_last,
    input  logic              i_ready,
    output logic [DW-1:0]     o_data,
    output logic [SW-1:0]     o_strb,
    output logic              o_valid,
    output logic              o_last,
    output logic [N-1:0]      o_ready
);

    // Indexed selection written as a compare loop so an out-of-range index yields zeros
    always_comb begin
        o_data  = '0;
        o_strb  = '0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (i_en && (i_sel == IW'(i))) begin
                o_data     = i_data[i*DW +: DW];
                o_strb     = i_strb[i*SW +: SW];
                o_valid    = i_valid[i];
                o_last     = i_last[i];
                o_ready[i] = i_ready;
            end else begin
                o_ready[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wdata_route_ctrl.sv
// ---------------------------------------------------------------------------
// wdata_route_ctrl
// W-channel router downstream of the write-response ID queue. Connects the
// master at the queue head to the shared slave W port for exactly one burst
// of Write_Data_Len+1 beats, pulses Write_Data_Finsh on the last beat so the
// queue pops, then spends one POP cycle before accepting the next head.
// Ports:
//   ACLK, ARESET         : clock, async active-high reset
//   Write_Data_Pending   : queue head valid
//   Write_Data_Master    : master index at head
//   Write_Data_Len       : AWLEN of head transaction
//   M_WDATA/M_WSTRB/M_WLAST/M_WVALID : packed master W inputs
//   M_WREADY             : per-master WREADY
//   S_WDATA/S_WSTRB/S_WLAST/S_WVALID : slave W outputs (WLAST from beat count)
//   S_WREADY             : slave WREADY
//   Write_Data_Finsh     : one-cycle pop pulse on last-beat handshake
//   Wlast_Error          : sticky, master WLAST position or index mismatch
//   Busy                 : high while in BURST
// ---------------------------------------------------------------------------
module wdata_route_ctrl
    import axi_ic_pkg::*;
#(
    parameter int Masters_Num = 2,
    parameter int ID_Size     = $clog2(Masters_Num),
    parameter int Data_Width  = DEF_DATA_WIDTH,
    parameter int Len_Width   = 8
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic                                     Write_Data_Pending,
    input  logic [ID_Size-1:0]                       Write_Data_Master,
    input  logic [Len_Width-1:0]                     Write_Data_Len,
    input  logic [Masters_Num*Data_Width-1:0]        M_WDATA,
    input  logic [Masters_Num*strb_width(Data_Width)-1:0] M_WSTRB,
    input  logic [Masters_Num-1:0]                   M_WLAST,
    input  logic [Masters_Num-1:0]                   M_WVALID,
    output logic [Masters_Num-1:0]                   M_WREADY,
    output logic [Data_Width-1:0]                    S_WDATA,
    output logic [strb_width(Data_Width)-1:0]        S_WSTRB,
    output logic                                     S_WLAST,
    output logic                                     S_WVALID,
    input  logic                                     S_WREADY,
    output logic                                     Write_Data_Finsh,
    output logic                                     Wlast_Error,
    output logic                                     Busy
);

    localparam int Strb_Width = strb_width(Data_Width);

    wr_route_state_e      r_state;
    logic [ID_Size-1:0]   r_sel;
    logic [Len_Width-1:0] r_beat_cnt;
    logic [Len_Width-1:0] r_len_q;
    logic                 r_wlast_error;
    logic                 r_busy;

    logic                 w_master_ok;
    logic                 w_in_burst;
    logic                 w_mux_valid;
    logic                 w_mux_last;
    logic                 w_last_beat;
    logic                 w_handshake;

    // Head index is legal only if it names an existing master
    always_comb begin
        w_master_ok = 1'b0;
        for (int i = 0; i < Masters_Num; i++) begin
            if (Write_Data_Master == ID_Size'(i)) begin
                w_master_ok = 1'b1;
            end else begin
                w_master_ok = w_master_ok;
            end
        end
    end

    assign w_in_burst  = (r_state == BURST);
    assign w_last_beat = w_in_burst && (r_beat_cnt == r_len_q);
    assign w_handshake = w_mux_valid & S_WREADY;

    wdata_slice_mux #(
        .N  (Masters_Num),
        .IW (ID_Size),
        .DW (Data_Width),
        .SW (Strb_Width)
    ) u_mux (
        .i_en    (w_in_burst),
        .i_sel   (r_sel),
        .i_data  (M_WDATA),
        .i_strb  (M_WSTRB),
        .i_valid (M_WVALID),
        .i_last  (M_WLAST),
        .i_ready (S_WREADY),
        .o_data  (S_WDATA),
        .o_strb  (S_WSTRB),
        .o_valid (w_mux_valid),
        .o_last  (w_mux_last),
        .o_ready (M_WREADY)
    );

    assign S_WVALID         = w_mux_valid;
    assign S_WLAST          = w_last_beat;
    assign Write_Data_Finsh = w_handshake & w_last_beat;
    assign Wlast_Error      = r_wlast_error;
    assign Busy             = r_busy;

    // Route FSM: latch head in IDLE, count beats in BURST, one dead cycle in POP
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= IDLE;
            r_sel         <= '0;
            r_beat_cnt    <= '0;
            r_len_q       <= '0;
            r_wlast_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Write_Data_Pending) begin
                        // An illegal index still runs the burst, routed to master 0
                        r_sel      <= w_master_ok ? Write_Data_Master : '0;
                        r_len_q    <= Write_Data_Len;
                        r_beat_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= BURST;
                        if (!w_master_ok) begin
                            r_wlast_error <= 1'b1;
                        end else begin
                            r_wlast_error <= r_wlast_error;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BURST: begin
                    if (w_handshake) begin
                        // Master WLAST is only checked, never forwarded
                        if (w_mux_last != w_last_beat) begin
                            r_wlast_error <= 1'b1;
                        end else begin
                            r_wlast_error <= r_wlast_error;
                        end
                        if (w_last_beat) begin
                            r_busy  <= 1'b0;
                            r_state <= POP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + Len_Width'(1);
                        end
                    end else begin
                        r_state <= BURST;
                    end
                end
                POP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdata_route_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wdata_route_ctrl
// Table-driven vectors for single bursts, hand sequences for backpressure,
// back-to-back bursts, WLAST mismatch and async reset, then randomized
// traffic compared against a beats-remaining reference model.
// ---------------------------------------------------------------------------
module tb_wdata_route_ctrl;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int LW = 8;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              pend;
    logic [IW-1:0]     mst;
    logic [LW-1:0]     len;
    logic [N*DW-1:0]   wdata;
    logic [N*SW-1:0]   wstrb;
    logic [N-1:0]      mwlast;
    logic [N-1:0]      mvalid;
    logic [N-1:0]      M_WREADY;
    logic [DW-1:0]     S_WDATA;
    logic [SW-1:0]     S_WSTRB;
    logic              S_WLAST;
    logic              S_WVALID;
    logic              sready;
    logic              Write_Data_Finsh;
    logic              Wlast_Error;
    logic              Busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 ACLK = ~ACLK;

    wdata_route_ctrl #(
        .Masters_Num (N),
        .ID_Size     (IW),
        .Data_Width  (DW),
        .Len_Width   (LW)
    ) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .Write_Data_Pending (pend),
        .Write_Data_Master  (mst),
        .Write_Data_Len     (len),
        .M_WDATA            (wdata),
        .M_WSTRB            (wstrb),
        .M_WLAST            (mwlast),
        .M_WVALID           (mvalid),
        .M_WREADY           (M_WREADY),
        .S_WDATA            (S_WDATA),
        .S_WSTRB            (S_WSTRB),
        .S_WLAST            (S_WLAST),
        .S_WVALID           (S_WVALID),
        .S_WREADY           (sready),
        .Write_Data_Finsh   (Write_Data_Finsh),
        .Wlast_Error        (Wlast_Error),
        .Busy               (Busy)
    );

    typedef struct packed {
        logic       pend;
        logic       mst;
        logic [7:0] len;
        logic [1:0] mvalid;
        logic [1:0] mwlast;
        logic       sready;
        logic [1:0] e_mready;
        logic       e_svalid;
        logic       e_slast;
        logic       e_finsh;
        logic       e_busy;
    } vec_t;

    typedef struct packed {
        logic       mst;
        logic [7:0] len;
    } ent_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic m, input logic [7:0] l,
                         input logic [1:0] mv, input logic [1:0] ml, input logic sr);
        pend   = p;
        mst    = m;
        len    = l;
        mvalid = mv;
        mwlast = ml;
        sready = sr;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic sample();
        @(negedge ACLK);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wready"}, 64'(M_WREADY), 64'(0));
        chk({name, "_svalid"}, 64'(S_WVALID), 64'(0));
        chk({name, "_slast"},  64'(S_WLAST), 64'(0));
        chk({name, "_finsh"},  64'(Write_Data_Finsh), 64'(0));
        chk({name, "_busy"},   64'(Busy), 64'(0));
        chk({name, "_err"},    64'(Wlast_Error), 64'(0));
        chk({name, "_data"},   64'(S_WDATA), 64'(0));
        chk({name, "_strb"},   64'(S_WSTRB), 64'(0));
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rdy_v;
        logic [4:0] lst_v;
        int         fin_cyc [$];
        logic [1:0] fin_rdy [$];
        int         head;
        int         bd;
        ent_t       q [$];
        logic       m_busy;
        logic       m_pop;
        logic       m_sel;
        int         m_left;
        logic [6:0] e_ctrl;
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_strb;
        logic       hs;
        logic       el;
        logic [1:0] emr;

        // ---------------- reset ----------------
        ARESET = 1'b1;
        wdata  = {32'h2222_0001, 32'h1111_0000};
        wstrb  = {4'hC, 4'h3};
        drive(1'b1, 1'b1, 8'd3, 2'b11, 2'b11, 1'b1);
        tick();
        sample();
        chk_all_zero("reset");
        tick();
        ARESET = 1'b0;

        // ---------------- table: Len=3 master 1, then Len=0 master 0 ----------------
        tbl[0]  = '{1'b1, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 8'd3, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'd0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pend, tbl[i].mst, tbl[i].len, tbl[i].mvalid, tbl[i].mwlast, tbl[i].sready);
            sample();
            chk($sformatf("tbl%0d_wready", i), 64'(M_WREADY), 64'(tbl[i].e_mready));
            chk($sformatf("tbl%0d_svalid", i), 64'(S_WVALID), 64'(tbl[i].e_svalid));
            chk($sformatf("tbl%0d_slast", i),  64'(S_WLAST), 64'(tbl[i].e_slast));
            chk($sformatf("tbl%0d_finsh", i),  64'(Write_Data_Finsh), 64'(tbl[i].e_finsh));
            chk($sformatf("tbl%0d_busy", i),   64'(Busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err", i),    64'(Wlast_Error), 64'(0));
            chk($sformatf("tbl%0d_data", i),   64'(S_WDATA),
                tbl[i].e_busy ? 64'(wdata[tbl[i].mst*DW +: DW]) : 64'(0));
            chk($sformatf("tbl%0d_strb", i),   64'(S_WSTRB),
                tbl[i].e_busy ? 64'(wstrb[tbl[i].mst*SW +: SW]) : 64'(0));
            tick();
        end

        // ---------------- Len=2 with slave backpressure 1,0,0,1,1 ----------------
        rdy_v = 5'b11001;
        lst_v = 5'b10000;
        drive(1'b1, 1'b0, 8'd2, 2'b01, 2'b00, 1'b1);
        sample();
        chk("bp_idle_busy", 64'(Busy), 64'(0));
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'd2, 2'b01, {1'b0, lst_v[i]}, rdy_v[i]);
            sample();
            chk($sformatf("bp%0d_svalid", i), 64'(S_WVALID), 64'(1));
            chk($sformatf("bp%0d_slast", i),  64'(S_WLAST), 64'(lst_v[i]));
            chk($sformatf("bp%0d_finsh", i),  64'(Write_Data_Finsh), 64'(lst_v[i]));
            chk($sformatf("bp%0d_wready", i), 64'(M_WREADY), 64'({1'b0, rdy_v[i]}));
            tick();
        end
        drive(1'b0, 1'b0, 8'd2, 2'b01, 2'b00, 1'b1);
        sample();
        chk("bp_pop_busy", 64'(Busy), 64'(0));
        chk("bp_pop_finsh", 64'(Write_Data_Finsh), 64'(0));
        tick();
        sample();
        chk("bp_idle2_svalid", 64'(S_WVALID), 64'(0));
        tick();

        // ---------------- back-to-back: master 0 Len=1 then master 1 Len=1 ----------------
        head = 0;
        bd   = 0;
        for (int c = 0; c < 20; c++) begin
            if (head < 2) begin
                drive(1'b1, head[0], 8'd1, 2'b11,
                      (bd == 1) ? (head == 0 ? 2'b01 : 2'b10) : 2'b00, 1'b1);
            end else begin
                drive(1'b0, 1'b0, 8'd1, 2'b11, 2'b00, 1'b1);
            end
            sample();
            if (S_WVALID && sready) bd++;
            if (Write_Data_Finsh) begin
                fin_cyc.push_back(c);
                fin_rdy.push_back(M_WREADY);
                head++;
                bd = 0;
            end
            tick();
        end
        chk("b2b_count", 64'(fin_cyc.size()), 64'(2));
        chk("b2b_gap", (fin_cyc.size() >= 2) ? 64'(fin_cyc[1] - fin_cyc[0]) : 64'(0), 64'(4));
        chk("b2b_rdy0", (fin_rdy.size() >= 1) ? 64'(fin_rdy[0]) : 64'(0), 64'(2'b01));
        chk("b2b_rdy1", (fin_rdy.size() >= 2) ? 64'(fin_rdy[1]) : 64'(0), 64'(2'b10));
        chk("b2b_err", 64'(Wlast_Error), 64'(0));

        // ---------------- Len=3, master WLAST early on beat 2 ----------------
        drive(1'b1, 1'b1, 8'd3, 2'b10, 2'b00, 1'b1);
        sample();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'd3, 2'b10, ((i == 1) || (i == 3)) ? 2'b10 : 2'b00, 1'b1);
            sample();
            chk($sformatf("wl%0d_err", i),   64'(Wlast_Error), 64'(i >= 2));
            chk($sformatf("wl%0d_slast", i), 64'(S_WLAST), 64'(i == 3));
            chk($sformatf("wl%0d_finsh", i), 64'(Write_Data_Finsh), 64'(i == 3));
            tick();
        end
        sample();
        chk("wl_pop_err", 64'(Wlast_Error), 64'(1));
        tick();

        // ---------------- async reset during beat 2 of Len=3 ----------------
        drive(1'b1, 1'b0, 8'd3, 2'b01, 2'b00, 1'b1);
        sample();
        tick();
        drive(1'b0, 1'b0, 8'd3, 2'b01, 2'b00, 1'b1);
        sample();
        chk("rst_beat1_svalid", 64'(S_WVALID), 64'(1));
        tick();
        #2;
        ARESET = 1'b1;
        #1;
        chk_all_zero("rst_async");
        tick();
        sample();
        chk_all_zero("rst_held");
        tick();
        ARESET = 1'b0;
        drive(1'b1, 1'b1, 8'd1, 2'b10, 2'b00, 1'b1);
        sample();
        chk("rst_idle_busy", 64'(Busy), 64'(0));
        tick();
        drive(1'b0, 1'b1, 8'd1, 2'b10, 2'b00, 1'b1);
        sample();
        chk("rst_b0_svalid", 64'(S_WVALID), 64'(1));
        chk("rst_b0_slast", 64'(S_WLAST), 64'(0));
        chk("rst_b0_wready", 64'(M_WREADY), 64'(2'b10));
        tick();
        drive(1'b0, 1'b1, 8'd1, 2'b10, 2'b10, 1'b1);
        sample();
        chk("rst_b1_slast", 64'(S_WLAST), 64'(1));
        chk("rst_b1_finsh", 64'(Write_Data_Finsh), 64'(1));
        tick();
        drive(1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0);
        sample();
        chk_all_zero("rst_pop");
        tick();

        // ---------------- randomized traffic vs beats-remaining model ----------------
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < 25; i++) begin
            q.push_back('{mst: 1'($urandom_range(0, 1)), len: 8'($urandom_range(0, 5))});
        end
        m_busy = 1'b0;
        m_pop  = 1'b0;
        m_sel  = 1'b0;
        m_left = 0;
        for (int c = 0; c < 500; c++) begin
            pend   = (q.size() != 0) && ($urandom_range(0, 3) != 0);
            mst    = (q.size() != 0) ? q[0].mst : 1'($urandom_range(0, 1));
            len    = (q.size() != 0) ? q[0].len : 8'($urandom_range(0, 255));
            mvalid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            sready = ($urandom_range(0, 3) != 0);
            wdata  = {$urandom, $urandom};
            wstrb  = 8'($urandom);
            mwlast = 2'($urandom_range(0, 3));
            if (m_busy) mwlast[m_sel] = (m_left == 1);
            if (m_busy) begin
                el       = (m_left == 1);
                hs       = mvalid[m_sel] & sready;
                emr      = 2'b00;
                emr[m_sel] = sready;
                e_ctrl   = {emr, mvalid[m_sel], el, hs & el, 1'b1, 1'b0};
                e_data   = wdata[m_sel*DW +: DW];
                e_strb   = wstrb[m_sel*SW +: SW];
            end else begin
                el     = 1'b0;
                hs     = 1'b0;
                e_ctrl = 7'd0;
                e_data = '0;
                e_strb = '0;
            end
            sample();
            chk($sformatf("rnd%0d_ctrl", c),
                64'({M_WREADY, S_WVALID, S_WLAST, Write_Data_Finsh, Busy, Wlast_Error}), 64'(e_ctrl));
            chk($sformatf("rnd%0d_data", c), 64'({S_WDATA, S_WSTRB}), 64'({e_data, e_strb}));
            if (m_busy) begin
                if (hs) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_pop  = 1'b1;
                        void'(q.pop_front());
                    end
                end
            end else if (m_pop) begin
                m_pop = 1'b0;
            end else if (pend) begin
                m_busy = 1'b1;
                m_sel  = mst;
                m_left = int'(len) + 1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wdata_route_ctrl.md
Name: wdata_route_ctrl

Overview:
- Write-data (W channel) router sitting directly downstream of the write-response ID queue.
- Takes the queued master ID at the head of the queue and connects that master's W channel to the shared slave W port for exactly one burst.
- Issues a one-cycle Write_Data_Finsh pulse on the last beat so the queue pops its head entry.
- Enforces burst length from the queued AWLEN and flags masters whose WLAST disagrees with it.

Parameters:
- Masters_Num, 2, number of upstream masters.
- ID_Size, $clog2(Masters_Num), width of the master index.
- Data_Width, 32, W data width in bits.
- Len_Width, 8, AWLEN width (beats = len+1).

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- Write_Data_Pending  in  1  level: queue non-empty, head entry valid.
- Write_Data_Master  in  ID_Size  master index at queue head.
- Write_Data_Len  in  Len_Width  AWLEN of the head transaction.
- M_WDATA  in  Masters_Num*Data_Width  packed master data, master i at [i*Data_Width +: Data_Width].
- M_WSTRB  in  Masters_Num*Data_Width/8  packed strobes.
- M_WLAST  in  Masters_Num  per-master WLAST.
- M_WVALID  in  Masters_Num  per-master WVALID.
- M_WREADY  out  Masters_Num  per-master WREADY.
- S_WDATA  out  Data_Width  slave data.
- S_WSTRB  out  Data_Width/8  slave strobes.
- S_WLAST  out  1  slave WLAST, generated from the beat count.
- S_WVALID  out  1  slave WVALID.
- S_WREADY  in  1  slave WREADY.
- Write_Data_Finsh  out  1  one-cycle pulse on the last-beat handshake (queue pop).
- Wlast_Error  out  1  sticky flag, master WLAST mismatched the expected position.
- Busy  out  1  high while in BURST.

Behaviour:
- Reset values (async, ARESET=1): state IDLE; Sel=0; Beat_Cnt=0; Len_Q=0; Wlast_Error=0. All outputs are 0: M_WREADY, S_WVALID, S_WLAST, Write_Data_Finsh, Busy, S_WDATA, S_WSTRB.
- FSM states: IDLE, BURST, POP.
- IDLE:
  - If Write_Data_Pending=1: latch Sel<=Write_Data_Master, Len_Q<=Write_Data_Len, Beat_Cnt<=0, then go to BURST.
  - If Write_Data_Master>=Masters_Num, Wlast_Error<=1; the burst still runs with Sel clamped to 0.
- BURST:
  - Combinational path: S_WVALID=M_WVALID[Sel]; M_WREADY[Sel]=S_WREADY; all other M_WREADY=0; S_WDATA and S_WSTRB are the slices for Sel.
  - S_WLAST=(Beat_Cnt==Len_Q).
  - Handshake occurs when S_WVALID&S_WREADY.
  - Non-last handshake: Beat_Cnt+1, which never wraps because it is bounded by Len_Q.
  - Last-beat handshake: Write_Data_Finsh=1 combinationally in that same cycle; next state POP.
- POP:
  - One idle cycle, all ready/valid outputs 0.
  - The queue's read pointer advances at the edge entering POP, so Write_Data_Master and Write_Data_Len are stable head values when the FSM returns to IDLE. Always go to IDLE next.
- Latency: pending to first possible beat is 1 cycle (IDLE->BURST). Back-to-back bursts add 2 dead cycles (POP and IDLE).
- Wlast_Error is set on any handshake where M_WLAST[Sel]!=S_WLAST. The burst length still follows Len_Q and master WLAST is never forwarded. The flag clears only on reset.
- Len_Q=0 is a single beat: the first handshake is the last beat.
- Slave backpressure (S_WREADY=0) holds Beat_Cnt and state indefinitely.
- Master deasserting WVALID mid-burst: no handshake, no count.
- Write_Data_Pending dropping during BURST is ignored because the burst is already committed.
- Reset asserted mid-burst: immediate return to reset values. No Finsh pulse is emitted; the upstream queue is reset by the same domain.
- Write_Data_Finsh is never high for two consecutive cycles.

Decomposition:
- Shared package axi_ic_pkg holds:
  - enum wr_route_state_e {IDLE, BURST, POP};
  - localparams for strobe width (Data_Width/8).
- One sub-module is natural: wdata_slice_mux (parameterised one-hot/indexed mux of data, strobe and valid by Sel). It is reusable by the read path.

Test Plan:
1. Pending=1, Master=1, Len=3, M_WVALID[1] and S_WREADY held 1:
   - 4 beats pass.
   - S_WLAST only on beat 4.
   - Finsh pulses once in the beat-4 cycle.
   - M_WREADY[0]=0 throughout.
   - Busy=0 two cycles later.
2. Len=0, master 0 valid:
   - Single beat with S_WLAST=1 and Finsh on the first handshake.
   - POP then IDLE.
3. Len=2, S_WREADY toggling 1,0,0,1,1:
   - Beat_Cnt advances only on ready cycles.
   - Finsh appears on the 3rd handshake (cycle 5).
4. Queue holds master 0 (Len=1), then master 1 (Len=1), pending held high:
   - Master 0 beats, POP, IDLE, then master 1 beats.
   - Exactly 2 Finsh pulses, separated by at least 4 cycles.
5. Len=3, master asserts WLAST on beat 2:
   - Wlast_Error=1 after that edge.
   - Burst still completes 4 beats with S_WLAST on beat 4.
6. ARESET pulsed during beat 2 of a Len=3 burst:
   - All outputs 0 asynchronously and no Finsh.
   - After release, with Pending=1, a new burst starts cleanly with Beat_Cnt=0.
